hazard_controller: RTL

//  Issue scheduler between decode and execute for the RV32E core. Holds a per-register

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hc_pending_counter.sv | 51 +++++
 rtl/hazard_controller.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and sizing for the RV32E issue hazard controller.
//   hc_state_t     : controller sequencing states
//   REG_IDX_W      : register index width
//   NUM_REGS_E     : architectural register count (x0 never tracked)
//   MAX_PENDING_D  : default outstanding writes per register
//   REFILL_HOLD_D  : default post-flush issue hold, in cycles
package hazard_pkg;

  localparam int unsigned REG_IDX_W     = 4;
  localparam int unsigned NUM_REGS_E    = 16;
  localparam int unsigned MAX_PENDING_D = 3;
  localparam int unsigned REFILL_HOLD_D = 2;

  typedef enum logic [1:0] {
    HC_RUN    = 2'd0,
    HC_FLUSH  = 2'd1,
    HC_REFILL = 2'd2
  } hc_state_t;

endpackage

// File: rtl/hc_pending_counter.sv
// Saturating up/down counter of outstanding writebacks for one register.
//   clock, nreset : clock and async active-low reset
//   inc           : a write to this register issues
//   dec           : a write to this register retires
//   clr           : drop all outstanding entries (squash)
//   count         : current outstanding count
//   busy          : registered count != 0
//   underflow_c   : retire seen with nothing outstanding (combinational)
module hc_pending_counter
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 3,
  localparam int unsigned CNT_W    = $clog2(MAX_COUNT + 1)
) (
  input  logic             clock,
  input  logic             nreset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             underflow_c
);

  logic [CNT_W-1:0] count_next;

  // Next count; simultaneous inc/dec nets to no change.
  always_comb begin
    count_next  = count;
    underflow_c = dec && !clr && (count == '0);
    if (clr) begin
      count_next = '0;
    end else if (inc && !dec) begin
      if (count != CNT_W'(MAX_COUNT)) count_next = count + CNT_W'(1);
    end else if (dec && !inc) begin
      if (count != '0) count_next = count - CNT_W'(1);
    end
  end

  // Count and busy flag registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      count <= '0;
      busy  <= 1'b0;
    end else begin
      count <= count_next;
      busy  <= (count_next != '0);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Issue scheduler between decode and execute: per-register writeback scoreboard,
// RAW/overflow stall, and redirect sequencing (flush pulse, then refill hold).
// Optional HAZARD_WB_BYPASS_EN waives a source hazard when its last pending write
// retires in the same cycle.
//   clock, nreset          : clock and async active-low reset
//   issue_*                : decode instruction presentation; issue_ready grants
//   wb_valid, wb_rd        : execute register writeback
//   redirect_valid/_pc     : execute taken branch/jump
//   flush                  : decode/fetch flush
//   fetch_redirect_valid/_pc : one-cycle redirect to fetch with latched target
//   busy_mask              : per-register pending != 0
//   error                  : sticky writeback-underflow error
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_PENDING = MAX_PENDING_D,
  parameter int unsigned REFILL_HOLD = REFILL_HOLD_D
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  issue_valid,
  input  logic [REG_IDX_W-1:0]  issue_rs1,
  input  logic [REG_IDX_W-1:0]  issue_rs2,
  input  logic                  issue_uses_rs1,
  input  logic                  issue_uses_rs2,
  input  logic [REG_IDX_W-1:0]  issue_rd,
  input  logic                  issue_writes_rd,
  output logic                  issue_ready,
  input  logic                  wb_valid,
  input  logic [REG_IDX_W-1:0]  wb_rd,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  flush,
  output logic                  fetch_redirect_valid,
  output logic [31:0]           fetch_redirect_pc,
  output logic [NUM_REGS_E-1:0] busy_mask,
  output logic                  error
);

  localparam int unsigned CNT_W  = $clog2(MAX_PENDING + 1);
  localparam int unsigned HOLD_W = 4;

  hc_state_t         state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;

  logic [CNT_W-1:0]      count [NUM_REGS_E];
  logic [NUM_REGS_E-1:0] busy_q;
  logic [NUM_REGS_E-1:0] underflow;

  logic hazard_rs1, hazard_rs2, hazard_rd;
  logic fire_wr, wb_run, clr;

  // x0 is hard-wired idle.
  assign count[0]     = '0;
  assign busy_q[0]    = 1'b0;
  assign underflow[0] = 1'b0;
  assign busy_mask    = busy_q;

  // Hazard detection and issue grant.
  always_comb begin
    hazard_rs1 = issue_uses_rs1 && busy_q[issue_rs1];
    hazard_rs2 = issue_uses_rs2 && busy_q[issue_rs2];
`ifdef HAZARD_WB_BYPASS_EN
    if (wb_valid && (wb_rd == issue_rs1) && (count[issue_rs1] == CNT_W'(1))) hazard_rs1 = 1'b0;
    if (wb_valid && (wb_rd == issue_rs2) && (count[issue_rs2] == CNT_W'(1))) hazard_rs2 = 1'b0;
`endif
    hazard_rd   = issue_writes_rd && (issue_rd != '0) &&
                  (count[issue_rd] == CNT_W'(MAX_PENDING));
    issue_ready = (state == HC_RUN) && !error && !hazard_rs1 && !hazard_rs2 && !hazard_rd;
    // A fire coinciding with a redirect is squashed and never scoreboarded.
    fire_wr     = issue_valid && issue_ready && !redirect_valid &&
                  issue_writes_rd && (issue_rd != '0);
    wb_run      = wb_valid && (state == HC_RUN);
    clr         = (state == HC_FLUSH);
  end

  // One pending counter per tracked register.
  for (genvar r = 1; r < NUM_REGS_E; r++) begin : g_pending
    hc_pending_counter #(.MAX_COUNT(MAX_PENDING)) u_cnt (
      .clock       (clock),
      .nreset      (nreset),
      .inc         (fire_wr && (issue_rd == REG_IDX_W'(r))),
      .dec         (wb_run && (wb_rd == REG_IDX_W'(r))),
      .clr         (clr),
      .count       (count[r]),
      .busy        (busy_q[r]),
      .underflow_c (underflow[r])
    );
  end

  // Redirect sequencing: any redirect (re)enters FLUSH; REFILL counts down the hold.
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    case (state)
      HC_RUN: begin
        if (redirect_valid) state_next = HC_FLUSH;
      end
      HC_FLUSH: begin
        if (!redirect_valid) begin
          state_next    = HC_REFILL;
          hold_cnt_next = HOLD_W'(REFILL_HOLD - 1);
        end
      end
      HC_REFILL: begin
        if (redirect_valid) begin
          state_next = HC_FLUSH;
        end else if (hold_cnt == '0) begin
          state_next = HC_RUN;
        end else begin
          hold_cnt_next = hold_cnt - HOLD_W'(1);
        end
      end
      default: state_next = HC_RUN;
    endcase
  end

  // State and registered outputs; flush and fetch redirect align with FLUSH.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state                <= HC_RUN;
      hold_cnt             <= '0;
      flush                <= 1'b0;
      fetch_redirect_valid <= 1'b0;
      fetch_redirect_pc    <= '0;
      error                <= 1'b0;
    end else begin
      state                <= state_next;
      hold_cnt             <= hold_cnt_next;
      flush                <= (state_next == HC_FLUSH);
      fetch_redirect_valid <= (state_next == HC_FLUSH);
      if (redirect_valid) fetch_redirect_pc <= redirect_pc;
      error                <= error || (|underflow);
    end
  end

endmodule
